// File: rtl/srt_div_sequencer.sv
// srt_div_sequencer: queues tagged divide requests and runs the SRT divider's
// clear/start/done protocol one operation at a time. Zero divisors are answered
// locally; a watchdog bounds the wait for the divider's done.
//
// Handshakes: a transfer happens on any rising edge where valid and ready are
// both high; a valid source keeps its payload stable until that edge, and ready
// may depend on internal state only (never combinationally on valid).
module srt_div_sequencer #(
    parameter int N       = 16,
    parameter int TAG_W   = 4,
    parameter int DEPTH   = 2,
    parameter int TIMEOUT = 2*N+8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_x,
    input  logic [N-1:0]     in_y,
    input  logic             in_signed,
    input  logic [TAG_W-1:0] in_tag,
    output logic             div_rst,
    output logic             div_start,
    output logic             div_signed,
    output logic [N-1:0]     div_x,
    output logic [N-1:0]     div_y,
    input  logic             div_done,
    input  logic [N-1:0]     div_q,
    input  logic [N-1:0]     div_r,
    input  logic             div_dbz,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_q,
    output logic [N-1:0]     out_r,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_dbz,
    output logic             out_timeout,
    output logic [2:0]       dbg_state
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = 2*N + 1 + TAG_W;
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [AW:0] PTR_ONE = 1;
    localparam logic [CW-1:0] CNT_ONE = 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLR   = 3'd1,
        S_START = 3'd2,
        S_WAIT  = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    state_t            state_q;
    logic [CW-1:0]     cnt_q;
    logic              clr_q, start_q, signed_q;
    logic [N-1:0]      x_q, y_q, q_q, r_q;
    logic [TAG_W-1:0]  tag_q;
    logic              valid_q, dbz_q, timeout_q;

    // Request FIFO: pointers carry one extra wrap bit to tell full from empty.
    logic [EW-1:0]     mem_q [DEPTH];
    logic [AW:0]       wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d;
    logic              full, empty, push, pop;
    logic [EW-1:0]     head;
    logic [N-1:0]      head_x, head_y;
    logic              head_signed;
    logic [TAG_W-1:0]  head_tag;

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    // in_ready is low when full, so a same-cycle pop never lets a push through.
    assign in_ready = rst & ~full;
    assign push     = in_valid & in_ready;
    assign pop      = (state_q == S_IDLE) & ~empty;

    assign head        = mem_q[rd_ptr_q[AW-1:0]];
    assign head_x      = head[EW-1 -: N];
    assign head_y      = head[EW-1-N -: N];
    assign head_signed = head[TAG_W];
    assign head_tag    = head[TAG_W-1:0];

    // Next pointer values from this cycle's push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    // FIFO storage: entries need no reset, the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= {in_x, in_y, in_signed, in_tag};
    end

    // FIFO pointers; reset empties the queue.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Sequencer FSM with all outputs registered on state transitions.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            clr_q     <= 1'b0;
            start_q   <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            signed_q  <= 1'b0;
            tag_q     <= '0;
            valid_q   <= 1'b0;
            q_q       <= '0;
            r_q       <= '0;
            dbz_q     <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!empty) begin
                        x_q      <= head_x;
                        y_q      <= head_y;
                        signed_q <= head_signed;
                        tag_q    <= head_tag;
                        if (head_y == '0) begin
                            // Divide by zero never reaches the divider.
                            q_q       <= '1;
                            r_q       <= head_x;
                            dbz_q     <= 1'b1;
                            timeout_q <= 1'b0;
                            valid_q   <= 1'b1;
                            state_q   <= S_RESP;
                        end else begin
                            clr_q   <= 1'b1;
                            state_q <= S_CLR;
                        end
                    end
                end
                S_CLR: begin
                    clr_q   <= 1'b0;
                    start_q <= 1'b1;
                    state_q <= S_START;
                end
                S_START: begin
                    start_q <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    // done has priority over a watchdog expiring in the same cycle.
                    if (div_done) begin
                        q_q       <= div_q;
                        r_q       <= div_r;
                        dbz_q     <= div_dbz;
                        timeout_q <= 1'b0;
                        valid_q   <= 1'b1;
                        state_q   <= S_RESP;
                    end else if (cnt_q == CNT_LAST) begin
                        q_q       <= '0;
                        r_q       <= '0;
                        dbz_q     <= 1'b0;
                        timeout_q <= 1'b1;
                        valid_q   <= 1'b1;
                        state_q   <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                S_RESP: begin
                    if (out_ready) begin
                        valid_q <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // The divider is held cleared for as long as reset is low.
    assign div_rst     = ~rst | clr_q;
    assign div_start   = start_q;
    assign div_signed  = signed_q;
    assign div_x       = x_q;
    assign div_y       = y_q;
    assign out_valid   = valid_q;
    assign out_q       = q_q;
    assign out_r       = r_q;
    assign out_tag     = tag_q;
    assign out_dbz     = dbz_q;
    assign out_timeout = timeout_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_srt_div_sequencer.sv
// tb_srt_div_sequencer: drives tagged requests into srt_div_sequencer, plays the
// divider with a small behavioural model, and checks responses via a scoreboard.
module tb_srt_div_sequencer;

    localparam int N       = 16;
    localparam int TAG_W   = 4;
    localparam int DEPTH   = 2;
    localparam int TIMEOUT = 2*N+8;
    localparam int EW      = TAG_W + 2*N + 2;   // {tag, q, r, dbz, timeout}

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [N-1:0]     in_x = '0, in_y = '0;
    logic             in_signed = 1'b0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             div_rst, div_start, div_signed;
    logic [N-1:0]     div_x, div_y;
    logic             div_done = 1'b0;
    logic [N-1:0]     div_q = '0, div_r = '0;
    logic             div_dbz = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [N-1:0]     out_q, out_r;
    logic [TAG_W-1:0] out_tag;
    logic             out_dbz, out_timeout;
    logic [2:0]       dbg_state;

    srt_div_sequencer #(.N(N), .TAG_W(TAG_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y),
        .in_signed(in_signed), .in_tag(in_tag),
        .div_rst(div_rst), .div_start(div_start), .div_signed(div_signed),
        .div_x(div_x), .div_y(div_y), .div_done(div_done), .div_q(div_q),
        .div_r(div_r), .div_dbz(div_dbz),
        .out_valid(out_valid), .out_ready(out_ready), .out_q(out_q), .out_r(out_r),
        .out_tag(out_tag), .out_dbz(out_dbz), .out_timeout(out_timeout),
        .dbg_state(dbg_state)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference divider: truncating quotient; signed remainder is reported as a magnitude.
    function automatic logic [2*N-1:0] div_model(input logic [N-1:0] x, input logic [N-1:0] y,
                                                 input logic s);
        logic [N-1:0] q, r, ax, ay;
        if (!s) begin
            q = x / y;
            r = x % y;
        end else begin
            ax = x[N-1] ? -x : x;
            ay = y[N-1] ? -y : y;
            q  = $signed(x) / $signed(y);
            r  = ax % ay;
        end
        return {q, r};
    endfunction

    // ---------------- divider model ----------------
    int             model_lat  = 0;
    logic           model_hang = 1'b0;
    logic           m_busy = 1'b0;
    int             m_cnt = 0;
    logic [2*N-1:0] m_res = '0;

    always @(posedge clk) begin
        div_done <= 1'b0;
        if (!rst || div_rst) begin
            m_busy <= 1'b0;
        end else if (div_start) begin
            m_busy <= !model_hang;
            m_cnt  <= model_lat;
            m_res  <= div_model(div_x, div_y, div_signed);
        end else if (m_busy) begin
            if (m_cnt == 0) begin
                m_busy   <= 1'b0;
                div_done <= 1'b1;
                div_q    <= m_res[2*N-1:N];
                div_r    <= m_res[N-1:0];
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end
    end

    // ---------------- scoreboard ----------------
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] mon_e;

    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("resp_unexpected", 64'(out_tag), 64'hFFFF);
            end else begin
                mon_e = exp_q.pop_front();
                check("resp_tag", 64'(out_tag), 64'(mon_e[EW-1 -: TAG_W]));
                check("resp_q", 64'(out_q), 64'(mon_e[2*N+1 -: N]));
                check("resp_r", 64'(out_r), 64'(mon_e[N+1 -: N]));
                check("resp_dbz", 64'(out_dbz), 64'(mon_e[1]));
                check("resp_timeout", 64'(out_timeout), 64'(mon_e[0]));
            end
        end
    end

    // ---------------- drivers ----------------
    // Offers one request until accepted; t returns the cycle index of the accepting edge.
    task automatic send(input logic [N-1:0] x, input logic [N-1:0] y, input logic s,
                        input logic [TAG_W-1:0] tag, input logic [EW-1:0] e, output int t);
        logic accepted;
        accepted  = 1'b0;
        in_valid  = 1'b1;
        in_x      = x;
        in_y      = y;
        in_signed = s;
        in_tag    = tag;
        for (int k = 0; k < 300 && !accepted; k++) begin
            if (in_ready) accepted = 1'b1;
            @(posedge clk);
            #1;
        end
        t = cyc;
        in_valid = 1'b0;
        check("in_accept", 64'(accepted), 64'd1);
        if (accepted) exp_q.push_back(e);
    endtask

    // One request with out_ready high; checks the divider protocol and latencies.
    task automatic run_one(input logic [N-1:0] x, input logic [N-1:0] y, input logic s,
                           input logic [TAG_W-1:0] tag, input int lat, input logic hang,
                           input logic [N-1:0] eq, input logic [N-1:0] er);
        int t, c_rst, c_start, c_done, c_valid, n_rst, n_start;
        logic [N-1:0] sx, sy;
        logic sig_bad, zero, to;
        zero = (y == '0);
        to   = !zero && hang;
        model_lat  = lat;
        model_hang = hang;
        out_ready  = 1'b1;
        c_rst = -1; c_start = -1; c_done = -1; c_valid = -1;
        n_rst = 0; n_start = 0; sig_bad = 1'b0; sx = '0; sy = '0;
        send(x, y, s, tag, {tag, to ? '0 : eq, to ? '0 : er, zero, to}, t);
        for (int k = 0; k < 200 && c_valid < 0; k++) begin
            @(posedge clk);
            #1;
            if (div_rst) begin
                n_rst++;
                if (c_rst < 0) c_rst = cyc;
            end
            if (div_start) begin
                n_start++;
                if (c_start < 0) begin
                    c_start = cyc;
                    sx = div_x;
                    sy = div_y;
                end
            end
            if (div_done && c_done < 0) c_done = cyc;
            if (c_rst >= 0 && div_signed !== s) sig_bad = 1'b1;
            if (out_valid) c_valid = cyc;
        end
        check("resp_seen", 64'(c_valid >= 0), 64'd1);
        if (zero) begin
            check("dbz_no_clr", 64'(n_rst), 64'd0);
            check("dbz_no_start", 64'(n_start), 64'd0);
            check("dbz_latency", 64'(c_valid - t), 64'd1);
        end else begin
            check("clr_cycles", 64'(n_rst), 64'd1);
            check("clr_latency", 64'(c_rst - t), 64'd1);
            check("start_cycles", 64'(n_start), 64'd1);
            check("start_latency", 64'(c_start - t), 64'd2);
            check("div_x", 64'(sx), 64'(x));
            check("div_y", 64'(sy), 64'(y));
            check("div_signed", 64'(sig_bad), 64'd0);
            if (hang) check("timeout_latency", 64'(c_valid - c_start), 64'(TIMEOUT + 1));
            else      check("done_to_valid", 64'(c_valid - c_done), 64'd1);
        end
        @(posedge clk);
        #1;
        check("sb_drained", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_reset_outputs();
        check("rst_out", 64'({out_valid, out_q, out_r, out_tag, out_dbz, out_timeout}), 64'd0);
        check("rst_div", 64'({div_start, div_x, div_y, div_signed, in_ready, div_rst}), 64'd1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int t;
        logic seen;
        logic [N-1:0] rx, ry;
        logic rs;
        logic [2*N-1:0] res;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("idle_in_ready", 64'(in_ready), 64'd1);
        check("idle_div_rst", 64'(div_rst), 64'd0);

        // Unsigned 100/7, tag 3
        run_one(16'd100, 16'd7, 1'b0, 4'd3, 3, 1'b0, 16'h000E, 16'h0002);
        // Signed -100/7
        run_one(16'hFF9C, 16'h0007, 1'b1, 4'd5, 0, 1'b0, 16'hFFF2, 16'h0002);
        // Zero divisor
        run_one(16'h1234, 16'h0000, 1'b0, 4'd7, 0, 1'b0, 16'hFFFF, 16'h1234);

        // Three back-to-back requests with the consumer stalled
        model_lat  = 2;
        model_hang = 1'b0;
        out_ready  = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            rx  = 16'(1000 * i + 7);
            ry  = 16'(i + 2);
            res = div_model(rx, ry, 1'b0);
            send(rx, ry, 1'b0, 4'(i), {4'(i), res, 2'b00}, t);
        end
        check("full_in_ready", 64'(in_ready), 64'd0);
        repeat (20) @(posedge clk);
        #1;
        check("stall_in_ready", 64'(in_ready), 64'd0);
        check("stall_out_valid", 64'(out_valid), 64'd1);
        check("stall_out_tag", 64'(out_tag), 64'd1);
        out_ready = 1'b1;
        for (int k = 0; k < 200 && exp_q.size() != 0; k++) begin
            @(posedge clk);
            #1;
        end
        check("burst_drained", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;

        // Watchdog, then a normal request
        run_one(16'h0400, 16'h0003, 1'b0, 4'd9, 0, 1'b1, 16'h0, 16'h0);
        run_one(16'h0400, 16'h0003, 1'b0, 4'd10, 1, 1'b0, 16'h0155, 16'h0001);

        // Reset while in WAIT with one request queued
        model_hang = 1'b1;
        out_ready  = 1'b1;
        send(16'h0050, 16'h0004, 1'b0, 4'd11, {4'd11, 16'h0014, 16'h0000, 2'b00}, t);
        for (int k = 0; k < 20 && !div_start; k++) begin
            @(posedge clk);
            #1;
        end
        repeat (3) @(posedge clk);
        #1;
        send(16'h0060, 16'h0004, 1'b0, 4'd12, {4'd12, 16'h0018, 16'h0000, 2'b00}, t);
        rst = 1'b0;
        @(posedge clk);
        #1;
        exp_q.delete();
        check_reset_outputs();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs();
        rst = 1'b1;
        model_hang = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < TIMEOUT + 20; k++) begin
            @(posedge clk);
            #1;
            if (out_valid || div_start) seen = 1'b1;
        end
        check("no_activity_after_reset", 64'(seen), 64'd0);
        run_one(16'h00C8, 16'h000A, 1'b0, 4'd13, 2, 1'b0, 16'h0014, 16'h0000);

        // Randomised requests
        for (int i = 0; i < 10; i++) begin
            rx = 16'($urandom_range(0, 16'hFFFF));
            ry = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom_range(1, 16'hFFFE));
            rs = 1'($urandom_range(0, 1));
            res = (ry == '0) ? {16'hFFFF, rx} : div_model(rx, ry, rs);
            run_one(rx, ry, rs, 4'($urandom_range(0, 15)), $urandom_range(0, 12), 1'b0,
                    res[2*N-1:N], res[N-1:0]);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "simulation time limit");
    end

endmodule
